spi_slave: RTL

SPI responder for the Wishbone–SPI interface: the far-end counterpart of the on-chip SCK generator and master shifter. It oversamples an externally driven SCK, SS_n and MOSI on the system clock, shifts bytes in and out MSB-first in any of the four SPI modes, and exchanges bytes with the Wishbone register side through a one-byte TX holding register and a pulsed RX output. It lets the design act as an SPI peripheral and serves as a loopback partner for the master in system tests.

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_slave_if.sv | 38 +++
 rtl/spi_slave_pin_sync.sv | 39 +++
 rtl/spi_slave.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_pkg
// Purpose  : Shared SPI mode codes, FSM state type and synchroniser depth.
// Revision : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

  // Mode codes are {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI pins plus TX/RX byte handshake between slave and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
) ();
  import spi_slave_pkg::*;

  logic                  cpol;
  logic                  cpha;
  logic                  sck_in;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  busy;

  modport slave (
    input  cpol, cpha, sck_in, ss_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output cpol, cpha, sck_in, ss_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_slave_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Purpose  : Multi-flop synchroniser with rise/fall pulses from a history flop.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_sync
  import spi_slave_pkg::*;
#(
  parameter int   STAGES    = SPI_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign sync_out = r_sync[STAGES-1];
  assign rise     = r_sync[STAGES-1] & ~r_prev;
  assign fall     = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Oversampled SPI responder, all four modes, MSB-first, with a
//            one-word TX holding register and pulsed RX word output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int                CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_WIDTH - 1);

  logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall, w_mosi;
  logic w_unused_sck_level, w_unused_ss_level, w_unused_mosi_rise, w_unused_mosi_fall;

  // Chains reset low so a select still held across reset cannot look like a new falling edge
  spi_pin_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .async_in(bus.sck_in),
    .sync_out(w_unused_sck_level), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_ss_sync (
    .clk(clk), .rst(rst), .async_in(bus.ss_n),
    .sync_out(w_unused_ss_level), .rise(w_ss_rise), .fall(w_ss_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .async_in(bus.mosi),
    .sync_out(w_mosi), .rise(w_unused_mosi_rise), .fall(w_unused_mosi_fall)
  );

  spi_state_t            r_state;
  logic                  r_cpol, r_cpha;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift, r_rx_shift, r_hold, r_rx_data;
  logic                  r_hold_full, r_tx_ready, r_rx_valid, r_underrun;

  logic w_sample_edge, w_drive_edge;
  logic w_active, w_select, w_live, w_load, w_shift, w_sample, w_tx_write;

  // In every mode the edge that does not sample is the one that drives MISO
  always_comb begin
    w_sample_edge = 1'b0;
    w_drive_edge  = 1'b0;
    case ({r_cpol, r_cpha})
      SPI_MODE0, SPI_MODE3: begin
        w_sample_edge = w_sck_rise;
        w_drive_edge  = w_sck_fall;
      end
      SPI_MODE1, SPI_MODE2: begin
        w_sample_edge = w_sck_fall;
        w_drive_edge  = w_sck_rise;
      end
      default: ;
    endcase
  end

  assign w_active   = (r_state == ST_ACTIVE);
  assign w_select   = ~w_active & w_ss_fall;
  assign w_live     = w_active & ~w_ss_rise;
  assign w_load     = (w_select & ~r_cpha) | (w_live & w_drive_edge & (r_bit_cnt == '0));
  assign w_shift    = w_live & w_drive_edge & (r_bit_cnt != '0);
  assign w_sample   = w_live & w_sample_edge;
  assign w_tx_write = bus.tx_valid & r_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= w_load & ~r_hold_full;

      // A load sees the pre-write holding state; a same-cycle write refills it
      if (w_tx_write) begin
        r_hold <= bus.tx_data;
      end
      r_hold_full <= (r_hold_full & ~w_load) | w_tx_write;
      r_tx_ready  <= ~((r_hold_full & ~w_load) | w_tx_write);

      if (w_load) begin
        r_tx_shift <= r_hold_full ? r_hold : '0;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      case (r_state)
        ST_IDLE: begin
          r_cpol    <= bus.cpol;
          r_cpha    <= bus.cpha;
          r_bit_cnt <= '0;
          if (w_ss_fall) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
          end else if (w_sample) begin
            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
            if (r_bit_cnt == c_last_bit) begin
              r_rx_data  <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso        = r_tx_shift[DATA_WIDTH-1];
  assign bus.miso_oe     = w_active;
  assign bus.busy        = w_active;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_underrun;

endmodule
`default_nettype wire
